// File: rtl/riscv_pkg.sv
// Shared RISC-V core definitions: load/store size encodings and LSU state type.
package riscv_pkg;

    localparam logic [2:0] LDST_B  = 3'd0;
    localparam logic [2:0] LDST_H  = 3'd1;
    localparam logic [2:0] LDST_W  = 3'd2;
    localparam logic [2:0] LDST_BU = 3'd4;
    localparam logic [2:0] LDST_HU = 3'd5;

    typedef enum logic {
        LSU_IDLE,
        LSU_BUSY
    } lsu_state_t;

endpackage

// File: rtl/riscv_lsu_fmt.sv
// Combinational lane formatter: store byte enables / lane replication and
// load byte/half extraction with sign or zero extension.
module riscv_lsu_fmt
    import riscv_pkg::*;
(
    input  logic        st_we,
    input  logic [2:0]  st_size,
    input  logic [1:0]  st_lsb,
    input  logic [31:0] st_wd,
    output logic [3:0]  st_be,
    output logic [31:0] st_wd_fmt,
    input  logic [2:0]  ld_size,
    input  logic [1:0]  ld_lsb,
    input  logic [31:0] ld_rd,
    output logic [31:0] ld_data
);

    logic [7:0]  lane [4];
    logic [7:0]  byte_v;
    logic [15:0] half_v;

    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign lane[gi] = ld_rd[8*gi +: 8];
    end

    assign byte_v = lane[ld_lsb];
    assign half_v = ld_lsb[1] ? {lane[3], lane[2]} : {lane[1], lane[0]};

    always_comb begin
        st_be     = 4'b0000;
        st_wd_fmt = st_wd;
        case (st_size)
            LDST_B: begin
                st_be     = 4'b0001 << st_lsb;
                st_wd_fmt = {4{st_wd[7:0]}};
            end
            LDST_H: begin
                st_be     = st_lsb[1] ? 4'b1100 : 4'b0011;
                st_wd_fmt = {2{st_wd[15:0]}};
            end
            LDST_W:  st_be = 4'b1111;
            default: st_be = 4'b0000;
        endcase
        // Loads always fetch the whole word; lane selection happens on return.
        if (!st_we) begin
            st_be = 4'b1111;
        end
    end

    always_comb begin
        ld_data = 32'h0;
        case (ld_size)
            LDST_B:  ld_data = {{24{byte_v[7]}}, byte_v};
            LDST_BU: ld_data = {24'h0, byte_v};
            LDST_H:  ld_data = {{16{half_v[15]}}, half_v};
            LDST_HU: ld_data = {16'h0, half_v};
            LDST_W:  ld_data = ld_rd;
            default: ld_data = 32'h0;
        endcase
    end

endmodule

// File: rtl/riscv_lsu.sv
// Load/store unit: one word-aligned memory transaction per core request, with
// stall, timeout abort and load formatting. RISCV_LSU_MISALIGN_EN enables misalign trapping.
module riscv_lsu
    import riscv_pkg::*;
#(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        core_req_i,
    input  logic        core_we_i,
    input  logic [2:0]  core_size_i,
    input  logic [31:0] core_addr_i,
    input  logic [31:0] core_wd_i,
    output logic [31:0] core_rd_o,
    output logic        core_stall_o,
    output logic        core_err_o,
    output logic        core_misalign_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wd_o,
    input  logic [31:0] mem_rd_i,
    input  logic        mem_ready_i
);

    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);

    lsu_state_t       state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg;
    logic [2:0]       size_reg;
    logic [1:0]       lsb_reg;
    logic             mem_req_reg, mem_we_reg;
    logic [3:0]       mem_be_reg;
    logic [31:0]      mem_addr_reg, mem_wd_reg;

    logic        misalign, launch, timeout_hit, done;
    logic [3:0]  fmt_be;
    logic [31:0] fmt_wd, fmt_rd;

    riscv_lsu_fmt u_fmt (
        .st_we     (core_we_i),
        .st_size   (core_size_i),
        .st_lsb    (core_addr_i[1:0]),
        .st_wd     (core_wd_i),
        .st_be     (fmt_be),
        .st_wd_fmt (fmt_wd),
        .ld_size   (size_reg),
        .ld_lsb    (lsb_reg),
        .ld_rd     (mem_rd_i),
        .ld_data   (fmt_rd)
    );

`ifdef RISCV_LSU_MISALIGN_EN
    always_comb begin
        misalign = 1'b0;
        if (state_reg == LSU_IDLE && core_req_i) begin
            case (core_size_i)
                LDST_H, LDST_HU: misalign = core_addr_i[0];
                LDST_W:          misalign = |core_addr_i[1:0];
                default:         misalign = 1'b0;
            endcase
        end
    end
`else
    assign misalign = 1'b0;
`endif

    assign launch      = (state_reg == LSU_IDLE) && core_req_i && !misalign;
    assign timeout_hit = (state_reg == LSU_BUSY) && !mem_ready_i &&
                         (TIMEOUT != 0) && (cnt_reg == CNT_LAST);
    assign done        = (state_reg == LSU_BUSY) && (mem_ready_i || timeout_hit);

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            LSU_IDLE: if (launch) state_next = LSU_BUSY;
            LSU_BUSY: if (done)   state_next = LSU_IDLE;
            default:              state_next = LSU_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg    <= LSU_IDLE;
            cnt_reg      <= '0;
            size_reg     <= 3'd0;
            lsb_reg      <= 2'd0;
            mem_req_reg  <= 1'b0;
            mem_we_reg   <= 1'b0;
            mem_be_reg   <= 4'd0;
            mem_addr_reg <= 32'h0;
            mem_wd_reg   <= 32'h0;
        end else begin
            state_reg <= state_next;
            if (launch) begin
                cnt_reg      <= '0;
                size_reg     <= core_size_i;
                lsb_reg      <= core_addr_i[1:0];
                mem_req_reg  <= 1'b1;
                mem_we_reg   <= core_we_i;
                mem_be_reg   <= fmt_be;
                mem_addr_reg <= {core_addr_i[31:2], 2'b00};
                mem_wd_reg   <= fmt_wd;
            end else if (done) begin
                mem_req_reg <= 1'b0;
            end else if (state_reg == LSU_BUSY) begin
                cnt_reg <= cnt_reg + CNT_W'(1);
            end
        end
    end

    // The completion cycle releases the stall so the core advances past this request.
    assign core_stall_o    = core_req_i && !done && !misalign;
    assign core_err_o      = timeout_hit;
    assign core_rd_o       = timeout_hit ? 32'h0 : fmt_rd;
    assign core_misalign_o = misalign;
    assign mem_req_o       = mem_req_reg;
    assign mem_we_o        = mem_we_reg;
    assign mem_be_o        = mem_be_reg;
    assign mem_addr_o      = mem_addr_reg;
    assign mem_wd_o        = mem_wd_reg;

endmodule

// File: tb/tb_riscv_lsu.sv
// Self-checking bench for riscv_lsu: directed test-plan cases plus randomized
// transactions against a behavioural model of the memory interface.
module tb_riscv_lsu;

    localparam int TO_P = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        core_req = 1'b0;
    logic        core_we = 1'b0;
    logic [2:0]  core_size = 3'd0;
    logic [31:0] core_addr = 32'h0;
    logic [31:0] core_wd = 32'h0;
    logic [31:0] core_rd;
    logic        core_stall, core_err, core_misalign;
    logic        mem_req, mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr, mem_wd;
    logic [31:0] mem_rd = 32'h0;
    logic        mem_ready = 1'b0;

    int errors = 0;
    int checks = 0;

    riscv_lsu #(.TIMEOUT(TO_P), .CNT_W(8)) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .core_req_i      (core_req),
        .core_we_i       (core_we),
        .core_size_i     (core_size),
        .core_addr_i     (core_addr),
        .core_wd_i       (core_wd),
        .core_rd_o       (core_rd),
        .core_stall_o    (core_stall),
        .core_err_o      (core_err),
        .core_misalign_o (core_misalign),
        .mem_req_o       (mem_req),
        .mem_we_o        (mem_we),
        .mem_be_o        (mem_be),
        .mem_addr_o      (mem_addr),
        .mem_wd_o        (mem_wd),
        .mem_rd_i        (mem_rd),
        .mem_ready_i     (mem_ready)
    );

    always #5 clk = ~clk;

    // Reference model: size codes B=0 H=1 W=2 BU=4 HU=5
    function automatic logic [3:0] ref_be(input logic we, input logic [2:0] size, input logic [1:0] lsb);
        if (!we) return 4'hF;
        case (size)
            3'd0:    return 4'(1 << lsb);
            3'd1:    return 4'(3 << (2 * int'(lsb[1])));
            3'd2:    return 4'hF;
            default: return 4'h0;
        endcase
    endfunction

    function automatic logic [31:0] ref_wd(input logic [2:0] size, input logic [31:0] wd);
        case (size)
            3'd0:    return (wd & 32'hFF) * 32'h0101_0101;
            3'd1:    return (wd & 32'hFFFF) * 32'h0001_0001;
            default: return wd;
        endcase
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] size, input logic [1:0] lsb, input logic [31:0] rd);
        int b, h;
        b = int'((rd >> (8 * int'(lsb))) & 32'hFF);
        h = int'((rd >> (16 * int'(lsb[1]))) & 32'hFFFF);
        case (size)
            3'd0:    return 32'(b >= 128 ? b - 256 : b);
            3'd4:    return 32'(b);
            3'd1:    return 32'(h >= 32768 ? h - 65536 : h);
            3'd5:    return 32'(h);
            3'd2:    return rd;
            default: return 32'h0;
        endcase
    endfunction

    // Launches one request (from IDLE) and follows it to completion or timeout.
    // delay = BUSY cycles before mem_ready pulses; delay >= TO_P never answers.
    task automatic run_txn(input logic we, input logic [2:0] size, input logic [31:0] addr,
                           input logic [31:0] wd, input logic [31:0] rd, input int delay,
                           output logic [31:0] got_rd, output int stall_cyc);
        logic [31:0] e_addr, e_wd, e_rd;
        logic [3:0]  e_be;
        bit          fin, to;
        e_addr = {addr[31:2], 2'b00};
        e_be   = ref_be(we, size, addr[1:0]);
        e_wd   = ref_wd(size, wd);
        @(negedge clk);
        core_req = 1'b1; core_we = we; core_size = size; core_addr = addr; core_wd = wd;
        mem_ready = 1'b0;
        #1;
        checks++;
        if (core_stall !== 1'b1 || mem_req !== 1'b0) begin
            errors++;
            $display("FAIL launch: stall=%b mem_req=%b required stall=1 mem_req=0", core_stall, mem_req);
        end
        stall_cyc = 1;
        got_rd = 32'h0;
        fin = 0;
        for (int k = 0; k < TO_P && !fin; k++) begin
            @(negedge clk);
            core_we = 1'($urandom); core_size = 3'($urandom);
            core_addr = $urandom; core_wd = $urandom;
            mem_ready = (k == delay);
            mem_rd = (k == delay) ? rd : $urandom;
            #1;
            checks++;
            if (mem_req !== 1'b1 || mem_addr !== e_addr || mem_be !== e_be || mem_we !== we) begin
                errors++;
                $display("FAIL mem_if: req=%b addr=%h be=%b we=%b required 1 %h %b %b",
                         mem_req, mem_addr, mem_be, mem_we, e_addr, e_be, we);
            end
            if (we && (size == 3'd0 || size == 3'd1 || size == 3'd2)) begin
                checks++;
                if (mem_wd !== e_wd) begin
                    errors++;
                    $display("FAIL store_wd: wd=%h required %h", mem_wd, e_wd);
                end
            end
            to = (k == TO_P - 1) && (k != delay);
            if (k == delay || to) begin
                fin = 1;
                e_rd = to ? 32'h0 : ref_load(size, addr[1:0], rd);
                got_rd = core_rd;
                checks++;
                if (core_stall !== 1'b0 || core_err !== to) begin
                    errors++;
                    $display("FAIL complete: stall=%b err=%b required stall=0 err=%b", core_stall, core_err, to);
                end
                if (!we || to) begin
                    checks++;
                    if (core_rd !== e_rd) begin
                        errors++;
                        $display("FAIL load_data: rd=%h required %h (size=%0d addr=%h mem=%h)",
                                 core_rd, e_rd, size, addr, rd);
                    end
                end
            end else begin
                stall_cyc++;
                checks++;
                if (core_stall !== 1'b1 || core_err !== 1'b0) begin
                    errors++;
                    $display("FAIL busy: stall=%b err=%b required stall=1 err=0", core_stall, core_err);
                end
            end
        end
        $display("txn we=%b size=%0d addr=%h delay=%0d stall_cycles=%0d rd=%h", we, size, addr, delay, stall_cyc, got_rd);
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        core_req = 1'b0; mem_ready = 1'b0;
        #1;
        checks++;
        if (mem_req !== 1'b0 || core_stall !== 1'b0 || core_err !== 1'b0) begin
            errors++;
            $display("FAIL idle: mem_req=%b stall=%b err=%b required all 0", mem_req, core_stall, core_err);
        end
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if (mem_req !== 1'b0 || mem_we !== 1'b0 || mem_be !== 4'h0 || mem_addr !== 32'h0 ||
            mem_wd !== 32'h0 || core_stall !== 1'b0 || core_err !== 1'b0 || core_misalign !== 1'b0) begin
            errors++;
            $display("FAIL reset: req=%b we=%b be=%b addr=%h wd=%h stall=%b err=%b required all 0",
                     mem_req, mem_we, mem_be, mem_addr, mem_wd, core_stall, core_err);
        end
        @(negedge clk);
        rst = 1'b0;
        idle_cycle();
    endtask

    task automatic test_store();
        logic [31:0] r;
        int sc;
        run_txn(1'b1, 3'd2, 32'h104, 32'hDEADBEEF, 32'h0, 3, r, sc);
        checks++;
        if (sc !== 4) begin
            errors++;
            $display("FAIL sw_stall_cycles: got %0d required 4", sc);
        end
        idle_cycle();
        run_txn(1'b1, 3'd0, 32'h103, 32'h0000_00A5, 32'h0, 1, r, sc);
        idle_cycle();
    endtask

    task automatic test_load();
        logic [31:0] r;
        int sc;
        run_txn(1'b0, 3'd0, 32'h102, 32'h0, 32'h12F0_3456, 0, r, sc);
        checks++;
        if (r !== 32'hFFFF_FFF0) begin errors++; $display("FAIL lb: got %h required FFFFFFF0", r); end
        run_txn(1'b0, 3'd4, 32'h102, 32'h0, 32'h12F0_3456, 2, r, sc);
        checks++;
        if (r !== 32'h0000_00F0) begin errors++; $display("FAIL lbu: got %h required 000000F0", r); end
        run_txn(1'b0, 3'd1, 32'h102, 32'h0, 32'h8001_0000, 0, r, sc);
        checks++;
        if (r !== 32'hFFFF_8001) begin errors++; $display("FAIL lh: got %h required FFFF8001", r); end
        idle_cycle();
    endtask

    task automatic test_timeout();
        logic [31:0] r;
        int sc;
        run_txn(1'b0, 3'd2, 32'h200, 32'h0, 32'h5555_AAAA, 99, r, sc);
        checks++;
        if (sc !== TO_P || r !== 32'h0) begin
            errors++;
            $display("FAIL timeout: stall_cycles=%0d rd=%h required %0d 00000000", sc, r, TO_P);
        end
        run_txn(1'b0, 3'd2, 32'h204, 32'h0, 32'h1234_5678, 0, r, sc);
        checks++;
        if (sc !== 1 || r !== 32'h1234_5678) begin
            errors++;
            $display("FAIL after_timeout: stall_cycles=%0d rd=%h required 1 12345678", sc, r);
        end
        idle_cycle();
    endtask

    task automatic test_reset_busy();
        @(negedge clk);
        core_req = 1'b1; core_we = 1'b1; core_size = 3'd2; core_addr = 32'h300; core_wd = 32'hCAFE_F00D;
        @(negedge clk);
        rst = 1'b1;
        core_req = 1'b0;
        #1;
        checks++;
        if (mem_req !== 1'b0 || mem_be !== 4'h0 || core_stall !== 1'b0 || core_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_busy: req=%b be=%b stall=%b err=%b required 0 0000 0 0", mem_req, mem_be, core_stall, core_err);
        end
        @(negedge clk);
        rst = 1'b0; mem_ready = 1'b1;
        #1;
        checks++;
        if (core_err !== 1'b0 || core_stall !== 1'b0 || mem_req !== 1'b0) begin
            errors++;
            $display("FAIL late_ready: err=%b stall=%b req=%b required 0", core_err, core_stall, mem_req);
        end
        idle_cycle();
    endtask

    task automatic test_misalign();
`ifdef RISCV_LSU_MISALIGN_EN
        @(negedge clk);
        core_req = 1'b1; core_we = 1'b0; core_size = 3'd2; core_addr = 32'h101;
        #1;
        checks++;
        if (core_misalign !== 1'b1 || core_stall !== 1'b0) begin
            errors++;
            $display("FAIL misalign: flag=%b stall=%b required 1 0", core_misalign, core_stall);
        end
        idle_cycle();
`else
        logic [31:0] r;
        int sc;
        run_txn(1'b0, 3'd2, 32'h101, 32'h0, 32'hA1B2_C3D4, 0, r, sc);
        checks++;
        if (core_misalign !== 1'b0) begin
            errors++;
            $display("FAIL misalign_off: flag=%b required 0", core_misalign);
        end
        idle_cycle();
`endif
    endtask

    task automatic test_random();
        logic [2:0]  sizes [7];
        logic [31:0] r, a;
        logic [2:0]  s;
        int sc, d, e_sc;
        sizes = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3, 3'd7};
        for (int i = 0; i < 40; i++) begin
            s = sizes[$urandom_range(0, 6)];
            a = $urandom;
`ifdef RISCV_LSU_MISALIGN_EN
            if (s == 3'd1 || s == 3'd5) a[0] = 1'b0;
            if (s == 3'd2) a[1:0] = 2'b00;
`endif
            d = $urandom_range(0, 5);
            e_sc = (d < TO_P ? d : TO_P - 1) + 1;
            run_txn(1'($urandom), s, a, $urandom, $urandom, d, r, sc);
            checks++;
            if (sc !== e_sc) begin
                errors++;
                $display("FAIL rand_stall: got %0d required %0d", sc, e_sc);
            end
            if ($urandom_range(0, 2) == 0) idle_cycle();
        end
        idle_cycle();
    endtask

    initial begin
        test_reset();
        test_store();
        test_load();
        test_timeout();
        test_reset_busy();
        test_misalign();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/riscv_lsu.md
Name: riscv_lsu

Overview:
- Load/store unit. It is the responder to the core's memory-request signals: mem_req, mem_we and mem_size (LDST_*) from the main decoder, plus the ALU address and rs2 data.
- Converts each core request into a single word-aligned data-memory transaction with byte enables.
- Stalls the core until the memory answers or the transaction times out.
- On loads, returns the sign- or zero-extended result to the writeback mux (WB_LSU_DATA).

Parameters:
- TIMEOUT, 255: max BUSY cycles waiting for mem_ready_i before abort; 0 disables the timeout.
- CNT_W, 8: timeout counter width; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  asynchronous, active-high reset
- core_req_i  in  1  memory request from decoder (held until core_stall_o low)
- core_we_i  in  1  1 = store, 0 = load
- core_size_i  in  3  LDST_B/H/W/BU/HU
- core_addr_i  in  32  byte address from ALU
- core_wd_i  in  32  store data (rs2)
- core_rd_o  out  32  formatted load data; valid in the cycle core_stall_o falls
- core_stall_o  out  1  freeze PC/regfile while high
- core_err_o  out  1  one-cycle pulse: timeout abort
- core_misalign_o  out  1  misaligned access flag (see Optional Feature)
- mem_req_o  out  1  memory request
- mem_we_o  out  1  memory write
- mem_be_o  out  4  byte enables
- mem_addr_o  out  32  {addr[31:2],2'b00}
- mem_wd_o  out  32  lane-replicated store data
- mem_rd_i  in  32  memory read word
- mem_ready_i  in  1  memory done; single-cycle pulse

Behaviour:
- Reset values (asynchronous): state IDLE; mem_req_o, mem_we_o 0; mem_be_o 0; mem_addr_o, mem_wd_o 0; latched size/addr-lsb 0; counter 0.
- FSM, IDLE:
  - If core_req_i: latch we, size, addr[1:0] and formatted be/wd/addr into the mem_* registers; go BUSY.
  - Otherwise stay in IDLE.
  - mem_ready_i is ignored in IDLE.
- FSM, BUSY:
  - mem_req_o = 1; mem_* hold their latched values.
  - mem_ready_i = 1: go IDLE, clear mem_req_o.
  - Else, if TIMEOUT != 0 and counter == TIMEOUT-1: go IDLE, core_err_o = 1 this cycle, core_rd_o = 0.
  - Else counter += 1.
  - Counter clears on every entry to BUSY.
- core_stall_o (combinational) = core_req_i & ~(BUSY & (mem_ready_i | timeout_hit)).
- Latency: request at cycle N; mem_req_o high from N+1; earliest stall release at N+1 (minimum 2-cycle access).
- Relaunch: transactions start only from IDLE. The completion cycle never relaunches even though core_req_i is still high. A new request in the cycle after completion starts a new transaction.
- Core changes inputs during BUSY: ignored (latched copy used).
- Store format:
  - B: be = 4'b0001 << addr[1:0], wd = {4{wd[7:0]}}.
  - H: be = addr[1] ? 4'b1100 : 4'b0011, wd = {2{wd[15:0]}}.
  - W: be = 4'b1111, wd passthrough.
  - Any other size: be = 0; the transaction still completes.
- Load format (combinational from mem_rd_i and latched size/lsb):
  - B/BU: byte selected by addr[1:0], sign-/zero-extended.
  - H/HU: half selected by addr[1], sign-/zero-extended.
  - W: passthrough.
  - Other size: 0.
- Loads drive mem_be_o = 4'b1111 and mem_we_o = 0.
- Reset mid-transaction: abort immediately, no error pulse; a late mem_ready_i is ignored in IDLE.

Optional Feature:
- RISCV_LSU_MISALIGN_EN defined:
  - In IDLE, a request with H/HU and addr[0] = 1, or W and addr[1:0] != 0, raises core_misalign_o combinationally.
  - No transaction is started, core_stall_o stays 0 that cycle, state stays IDLE.
  - Intended to feed the trap logic alongside illegal_instr.
- Undefined: core_misalign_o tied 0; misaligned accesses proceed with low address bits handled by the format rules above.

Decomposition:
- riscv_pkg:
  - add lsu_state_t enum {LSU_IDLE, LSU_BUSY};
  - reuse the existing LDST_B/H/W/BU/HU constants (0, 1, 2, 4, 5).
- Sub-module riscv_lsu_fmt: purely combinational lane formatter (be/wd generation, load extraction and extension), instantiated once in the top.

Test Plan:
- SW at addr 0x104, wd 0xDEADBEEF, ready after 3 cycles -> mem_addr_o 0x104, be 4'b1111, wd 0xDEADBEEF, we 1; stall high 4 cycles then low.
- SB at 0x103, wd 0x000000A5 -> be 4'b1000, wd 0xA5A5A5A5.
- LB at 0x102, mem_rd_i 0x12F0_3456 -> core_rd_o 0xFFFF_FFF0.
- LBU at the same address and data -> core_rd_o 0x0000_00F0.
- LH at 0x102, mem_rd_i 0x8001_0000 -> core_rd_o 0xFFFF_8001.
- TIMEOUT = 4, no mem_ready_i -> stall drops at cycle N+4 with core_err_o pulse and core_rd_o 0. A following LW with immediate ready -> normal 2-cycle completion.
- Reset asserted in BUSY, then mem_ready_i pulses -> state IDLE, mem_req_o 0, no stall/err. With RISCV_LSU_MISALIGN_EN: LW at 0x101 -> core_misalign_o 1, mem_req_o never rises.
